// File: rtl/fifo_stream_reader.sv
// Frame reader: pops frame_len words from a registered-output FIFO and presents
// them as a valid/ready stream through a 3-entry skid queue.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  req_cnt_q, req_cnt_d;
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];
  logic                  done_q, done_d;

  logic                  rd_en_s;
  logic                  hs_s;
  logic                  last_s;
  logic [1:0]            cnt_after_pop_s;

  // Read gating uses only registered occupancy, so m_ready never reaches fifo_rd_en.
  assign rd_en_s = (state_q == ST_RUN) && cs && !fifo_empty &&
                   (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd3);
  assign m_valid    = (buf_cnt_q != 2'd0);
  assign m_data     = buf_q[0];
  assign last_s     = m_valid && (out_cnt_q == (len_q - LEN_ONE));
  assign m_last     = last_s;
  assign hs_s       = m_valid && m_ready;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign fifo_rd_en = rd_en_s;

  // Frame control: state, length latch, request/output counters, done pulse.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req_cnt_d = req_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && cs) begin
          if (frame_len != LEN_ZERO) begin
            len_d     = frame_len;
            req_cnt_d = LEN_ZERO;
            out_cnt_d = LEN_ZERO;
            state_d   = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rd_en_s) begin
          req_cnt_d = req_cnt_q + LEN_ONE;
          if ((req_cnt_q + LEN_ONE) == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // The final accepted word closes the frame regardless of the state above.
    if (hs_s) begin
      out_cnt_d = out_cnt_q + LEN_ONE;
      if (last_s) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        done_d = done_d;
      end
    end else begin
      out_cnt_d = out_cnt_d;
    end
  end

  // Output queue: pop shifts toward the head, then the returning FIFO word is appended.
  always_comb begin
    inflight_d = rd_en_s;
    buf_d      = buf_q;
    if (hs_s) begin
      buf_d[0]        = buf_q[1];
      buf_d[1]        = buf_q[2];
      buf_d[2]        = buf_q[2];
      cnt_after_pop_s = buf_cnt_q - 2'd1;
    end else begin
      cnt_after_pop_s = buf_cnt_q;
    end
    buf_cnt_d = cnt_after_pop_s;
    if (inflight_q) begin
      buf_cnt_d = cnt_after_pop_s + 2'd1;
      case (cnt_after_pop_s)
        2'd0:    buf_d[0] = fifo_data;
        2'd1:    buf_d[1] = fifo_data;
        2'd2:    buf_d[2] = fifo_data;
        default: buf_d[2] = buf_d[2];
      endcase
    end else begin
      buf_cnt_d = cnt_after_pop_s;
    end
  end

  // State registers; reset wins over every other update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= LEN_ZERO;
      req_cnt_q  <= LEN_ZERO;
      out_cnt_q  <= LEN_ZERO;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      done_q     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= DATA_ZERO;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      done_q     <= done_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural registered-read FIFO.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs;
  logic          start;
  logic [LW-1:0] frame_len;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] exp_q[$];
  logic          rd_prev;

  int acc, rd_cnt, done_seen, cs_low_acc;
  logic          stall_pend;
  logic [DW-1:0] held_data;
  logic          held_last;

  fifo_stream_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .start(start), .frame_len(frame_len),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the FIFO model returns popped data one cycle after rd_en.
  task automatic cyc();
    rd_prev = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_prev) begin
      if (fifo_q.size() == 0) begin
        chk("pop_from_empty", 32'd1, 32'd0);
      end else begin
        fifo_data = fifo_q.pop_front();
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Per-cycle stream checks against the expected word queue.
  task automatic step_check(input int n);
    int ahead;
    if (stall_pend) begin
      chk("hold_data", m_data, held_data);
      chk("hold_last", 32'(m_last), 32'(held_last));
      stall_pend = 1'b0;
    end
    if (fifo_rd_en) begin
      chk("rd_while_empty", 32'(fifo_empty), 32'd0);
      rd_cnt++;
      ahead = rd_cnt - acc;
      chk("reads_ahead_le3", 32'(ahead <= 3), 32'd1);
    end
    if (!cs) chk("rd_while_cs_low", 32'(fifo_rd_en), 32'd0);
    if (m_valid && m_ready) begin
      chk("data", m_data, (acc < exp_q.size()) ? exp_q[acc] : 32'hDEAD_BEEF);
      chk("last", 32'(m_last), 32'(acc == n - 1));
      acc++;
      if (!cs) cs_low_acc++;
    end else if (m_valid) begin
      held_data  = m_data;
      held_last  = m_last;
      stall_pend = 1'b1;
    end
    if (done) begin
      done_seen++;
      chk("busy_in_done", 32'(busy), 32'd0);
    end
  endtask

  // Run one frame of n words; mode 1 toggles m_ready, cs low in [cs_lo,cs_hi).
  task automatic run_frame(input int n, input int mode, input int cs_lo, input int cs_hi,
                           input int refill_c);
    int c;
    acc = 0; rd_cnt = 0; done_seen = 0; cs_low_acc = 0; stall_pend = 1'b0;
    cs = 1'b1; start = 1'b1; frame_len = LW'(n); m_ready = 1'b0;
    #1;
    cyc();
    c = 1;
    while (done_seen == 0 && c < 300) begin
      m_ready   = (mode == 1) ? (c % 2 == 1) : 1'b1;
      cs        = !(c >= cs_lo && c < cs_hi);
      start     = (c == 2);
      frame_len = (c == 2) ? 8'd1 : LW'(n);
      if (c == refill_c) begin
        while (pend_q.size() > 0) push(pend_q.pop_front());
      end
      #1;
      step_check(n);
      if (done_seen == 0) cyc();
      c++;
    end
    chk("frame_done_seen", 32'(done_seen), 32'd1);
    chk("accepted_words", 32'(acc), 32'(n));
    chk("rd_pulses", 32'(rd_cnt), 32'(n));
    start = 1'b0;
    cyc();
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  int e_rd[8]    = '{0, 1, 1, 1, 1, 0, 0, 0};
  int e_valid[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  int e_last[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
  int e_done[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
  logic [DW-1:0] e_data[8] = '{32'h0, 32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cs = 1'b0; start = 1'b0; frame_len = 8'd0;
    fifo_empty = 1'b1; fifo_data = 32'h0; m_ready = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd", 32'(fifo_rd_en), 32'd0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_last", 32'(m_last), 32'd0);
    reset = 1'b0;
    cyc();

    // Basic four-word frame with a cycle-exact table.
    for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
    cs = 1'b1; m_ready = 1'b1; start = 1'b1; frame_len = 8'd4;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t37_rd", 32'(fifo_rd_en), 32'(e_rd[c]));
      chk("t37_valid", 32'(m_valid), 32'(e_valid[c]));
      if (e_valid[c] != 0) chk("t37_data", m_data, e_data[c]);
      chk("t37_last", 32'(m_last), 32'(e_last[c]));
      chk("t37_done", 32'(done), 32'(e_done[c]));
      chk("t37_busy", 32'(busy), 32'((c >= 1 && c <= 6) ? 1 : 0));
      cyc();
      start = 1'b0;
    end
    exp_q.delete();

    // Zero-length frame: done next cycle, no reads, never busy.
    start = 1'b1; frame_len = 8'd0; push(32'h55);
    #1;
    cyc();
    start = 1'b0;
    #1;
    chk("t40_done", 32'(done), 32'd1);
    chk("t40_busy", 32'(busy), 32'd0);
    chk("t40_rd", 32'(fifo_rd_en), 32'd0);
    cyc();
    #1;
    chk("t40_done_clear", 32'(done), 32'd0);
    chk("t40_busy2", 32'(busy), 32'd0);
    fifo_q.delete(); exp_q.delete(); fifo_empty = 1'b1;

    // Start with cs low is ignored.
    cs = 1'b0; start = 1'b1; frame_len = 8'd3;
    #1;
    cyc();
    start = 1'b0;
    #1;
    chk("cs_low_start_busy", 32'(busy), 32'd0);
    cyc();
    #1;
    chk("cs_low_start_done", 32'(done), 32'd0);

    // Five words with m_ready toggling.
    for (int i = 0; i < 5; i++) push(32'hB0 + 32'(i));
    run_frame(5, 1, 1000, 1000, -1);
    exp_q.delete();

    // FIFO runs dry after two of three words, refilled six cycles later.
    push(32'hC0); push(32'hC1); pend_q.push_back(32'hC2);
    run_frame(3, 0, 1000, 1000, 9);
    exp_q.delete();

    // cs low for three cycles mid-frame.
    for (int i = 0; i < 6; i++) push(32'hD0 + 32'(i));
    run_frame(6, 0, 3, 6, -1);
    chk("t42_drain_during_cs_low", 32'(cs_low_acc > 0), 32'd1);
    exp_q.delete();

    // Reset with two words buffered and one in flight.
    for (int i = 0; i < 4; i++) push(32'hE0 + 32'(i));
    cs = 1'b1; m_ready = 1'b0; start = 1'b1; frame_len = 8'd4;
    #1;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    #1;
    chk("t41_pre_valid", 32'(m_valid), 32'd1);
    chk("t41_pre_rd", 32'(fifo_rd_en), 32'd0);
    reset = 1'b1;
    #1;
    cyc();
    reset = 1'b0;
    #1;
    chk("t41_valid", 32'(m_valid), 32'd0);
    chk("t41_busy", 32'(busy), 32'd0);
    chk("t41_done", 32'(done), 32'd0);
    chk("t41_rd", 32'(fifo_rd_en), 32'd0);
    chk("t41_data", m_data, 32'h0);
    fifo_q.delete(); exp_q.delete(); fifo_empty = 1'b1;
    cyc();
    #1;
    chk("t41_no_done", 32'(done), 32'd0);
    push(32'hF0); push(32'hF1);
    run_frame(2, 0, 1000, 1000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO word and stream data.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of frame length and word counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  chip select; gates start acceptance and FIFO reads.
REQ-006 SHALL have port start  input  1  one-cycle frame request, sampled in IDLE only.
REQ-007 SHALL have port frame_len  input  LEN_WIDTH  number of words in frame, sampled with start.
REQ-008 SHALL have port fifo_empty  input  1  empty flag from the FIFO read side.
REQ-009 SHALL have port fifo_rd_en  output  1  FIFO pop request.
REQ-010 SHALL have port fifo_data  input  DATA_WIDTH  FIFO registered read data, valid the cycle after fifo_rd_en.
REQ-011 SHALL have port m_valid  output  1  stream word available.
REQ-012 SHALL have port m_ready  input  1  downstream accepts word.
REQ-013 SHALL have port m_data  output  DATA_WIDTH  stream word.
REQ-014 SHALL have port m_last  output  1  marks final word of frame, qualified by m_valid.
REQ-015 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN.
REQ-018 IDLE: start && cs && frame_len!=0 SHALL latch frame_len, clear req_cnt and out_cnt, go RUN next cycle.
REQ-019 IDLE: start && cs && frame_len==0 SHALL pulse done next cycle, no reads, stay IDLE.
REQ-020 start with cs low, or start outside IDLE, SHALL be ignored.
REQ-021 fifo_rd_en SHALL equal (state==RUN) && cs && !fifo_empty && (buf_cnt + inflight < 3); purely registered-state terms, no path from m_ready.
REQ-022 inflight SHALL be fifo_rd_en registered one cycle; when inflight is 1, fifo_data SHALL be written into the output buffer that cycle.
REQ-023 Output buffer SHALL be a 3-entry in-order queue; m_valid = (buf_cnt!=0); m_data = head entry.
REQ-024 Each fifo_rd_en SHALL increment req_cnt; RUN SHALL go DRAIN on the cycle req_cnt reaches the latched length.
REQ-025 Handshake is m_valid && m_ready; each SHALL pop the head and increment out_cnt.
REQ-026 m_last SHALL be high when m_valid and out_cnt == length-1.
REQ-027 Simultaneous buffer write and handshake SHALL leave buf_cnt unchanged and preserve order.
REQ-028 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-029 Steady state with FIFO non-empty and m_ready high SHALL sustain one word per cycle; first m_valid two cycles after first fifo_rd_en... i.e. fifo_rd_en at cycle N gives m_valid at N+2.
REQ-030 cs low mid-frame SHALL stall new reads only; in-flight capture and output handshakes continue.
REQ-031 fifo_empty high SHALL stall reads with no other effect; no read is ever issued while fifo_empty is high.
REQ-032 Handshake of the m_last word SHALL move to IDLE and pulse done for exactly the following cycle; busy low in that cycle.
REQ-033 Counters SHALL not wrap: frame_len = 2^LEN_WIDTH-1 maximum, req_cnt never exceeds length.

Reset
REQ-034 reset SHALL force IDLE, fifo_rd_en=0, inflight=0, buf_cnt=0, counters=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
REQ-035 reset mid-frame SHALL abort the frame, discard buffered and in-flight words, and produce no done pulse.
REQ-036 reset SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-037 FIFO holds 4 words 0xA0..0xA3, start len=4, m_ready=1 -> rd_en 4 consecutive cycles, m_data A0..A3 on consecutive cycles, m_last with A3, done one cycle after.
REQ-038 len=5, m_ready toggles 1,0,1,0 -> order preserved, data stable when stalled, never more than 3 reads ahead of acceptance, exactly 5 rd_en pulses.
REQ-039 FIFO empty after 2 of 3 words, refilled 6 cycles later -> rd_en low while empty, third word output afterwards, m_last on it.
REQ-040 start len=0 -> done pulse next cycle, no rd_en, busy stays 0.
REQ-041 reset asserted with 2 words buffered and 1 in flight -> next cycle m_valid=0, busy=0, done=0; fresh len=2 frame then completes normally.
REQ-042 cs low for 3 cycles mid-frame with m_ready=1 -> rd_en low those cycles, buffered words still drain, frame completes after cs returns.
